// File: rtl/poly_ram_pkg.sv
// Purpose: shared sizing defaults and FSM state type for the coefficient RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package poly_ram_pkg;

  // Default geometry: 64 words of two packed 12-bit coefficients.
  localparam int POLY_AW    = 6;
  localparam int POLY_DW    = 24;
  localparam int POLY_DEPTH = 2 ** POLY_AW;

  // CLEAR zero-fills the RAM, RUN serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-requester round-robin arbiter for one RAM port.
// Latency: grant is combinational from requests in the same cycle.
// Backpressure: the losing requester sees no grant and holds its request.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr = 0 favours requester 0 on the next contended cycle.
  logic ptr;

  // Uncontended requests win outright; a tie goes to the favoured side.
  always_comb begin
    gnt0 = en & req0 & (~req1 | ~ptr);
    gnt1 = en & req1 & (~req0 |  ptr);
  end

  // Move priority away from the winner only when both were asking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (gnt0 & req1) begin
      ptr <= 1'b1;
    end else if (gnt1 & req0) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/poly_ram_arbiter.sv
// Purpose: two-client arbiter onto a dual-port coefficient RAM, with zero-fill on reset/clear.
// Latency: requests granted combinationally; read data returned the cycle after acceptance.
// Backpressure: rq*_ready low while clearing or when the other client wins the port.
module poly_ram_arbiter
  import poly_ram_pkg::*;
#(
  parameter int AW = POLY_AW,
  parameter int DW = POLY_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rq0_valid,
  input  logic          rq0_we,
  input  logic [AW-1:0] rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  output logic          rq0_ready,
  input  logic          rq1_valid,
  input  logic          rq1_we,
  input  logic [AW-1:0] rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rq1_ready,
  output logic          rs0_valid,
  output logic [DW-1:0] rs0_rdata,
  output logic          rs1_valid,
  output logic [DW-1:0] rs1_rdata,
  input  logic          clear_req,
  output logic          init_done,
  output logic          mem_cea,
  output logic [AW-1:0] mem_ada,
  output logic [DW-1:0] mem_din,
  output logic          mem_ceb,
  output logic [AW-1:0] mem_adb,
  output logic          mem_oce,
  input  logic [DW-1:0] mem_dout
);

  state_e        state;
  logic [AW-1:0] clr_cnt;
  logic          run;
  logic          wg0, wg1, rg0, rg1;
  logic          wr_acc, rd_acc;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          rd_pend, rd_tag, rd_fwd;
  logic [DW-1:0] fwd_dat, resp_dat;

  assign run = (state == RUN);

  // Writes and reads compete on separate ports, so each gets its own arbiter.
  rr_arb2 u_wr_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run),
    .req0 (rq0_valid & rq0_we),
    .req1 (rq1_valid & rq1_we),
    .gnt0 (wg0),
    .gnt1 (wg1)
  );

  rr_arb2 u_rd_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run),
    .req0 (rq0_valid & ~rq0_we),
    .req1 (rq1_valid & ~rq1_we),
    .gnt0 (rg0),
    .gnt1 (rg1)
  );

  // Steer the winning client onto each port.
  always_comb begin
    wr_acc  = wg0 | wg1;
    rd_acc  = rg0 | rg1;
    wr_addr = wg1 ? rq1_addr  : rq0_addr;
    wr_data = wg1 ? rq1_wdata : rq0_wdata;
    rd_addr = rg1 ? rq1_addr  : rq0_addr;
  end

  // A client only ever asks for one port per cycle, so either grant readies it.
  assign rq0_ready = wg0 | rg0;
  assign rq1_ready = wg1 | rg1;
  assign init_done = run;

  // Port A carries the zero-fill while clearing. The reset term keeps the
  // write strobe quiet while the state flop is held in CLEAR by reset.
  assign mem_cea = rst_n & (~run | wr_acc);
  assign mem_ada = run ? wr_addr : clr_cnt;
  assign mem_din = run ? wr_data : '0;
  assign mem_ceb = rd_acc;
  assign mem_adb = rd_addr;
  assign mem_oce = 1'b1;

  // Zero-fill sweep; a clear request restarts it from address 0 at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      if (clear_req) begin
        clr_cnt <= '0;
      end else if (clr_cnt == {AW{1'b1}}) begin
        state   <= RUN;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + AW'(1);
      end
    end else if (clear_req) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end
  end

  // Remember who is owed read data next cycle, and capture same-address write
  // data because the RAM returns the old word on a read/write collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
      rd_fwd  <= 1'b0;
      fwd_dat <= '0;
    end else begin
      rd_pend <= rd_acc;
      rd_tag  <= rg1;
      rd_fwd  <= rd_acc & wr_acc & (rd_addr == wr_addr);
      fwd_dat <= wr_data;
    end
  end

  // Return data to the owning client only; idle outputs read as zero.
  always_comb begin
    resp_dat  = rd_fwd ? fwd_dat : mem_dout;
    rs0_valid = rd_pend & ~rd_tag;
    rs1_valid = rd_pend &  rd_tag;
    rs0_rdata = rs0_valid ? resp_dat : '0;
    rs1_rdata = rs1_valid ? resp_dat : '0;
  end

endmodule

// File: tb/tb_poly_ram_arbiter.sv
// Purpose: directed self-checking bench for poly_ram_arbiter with a behavioural RAM.
// Latency: checks sampled 1 ns after the falling edge, away from the active edge.
// Backpressure: stimulus holds requests while ready is low as a real client would.
module tb_poly_ram_arbiter;

  localparam int AW = 6;
  localparam int DW = 24;

  logic          clk;
  logic          rst_n;
  logic          rq0_valid, rq0_we, rq0_ready;
  logic [AW-1:0] rq0_addr;
  logic [DW-1:0] rq0_wdata;
  logic          rq1_valid, rq1_we, rq1_ready;
  logic [AW-1:0] rq1_addr;
  logic [DW-1:0] rq1_wdata;
  logic          rs0_valid, rs1_valid;
  logic [DW-1:0] rs0_rdata, rs1_rdata;
  logic          clear_req, init_done;
  logic          mem_cea, mem_ceb, mem_oce;
  logic [AW-1:0] mem_ada, mem_adb;
  logic [DW-1:0] mem_din, mem_dout;

  int errors = 0;
  int checks = 0;

  poly_ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rq0_valid(rq0_valid),
    .rq0_we   (rq0_we),
    .rq0_addr (rq0_addr),
    .rq0_wdata(rq0_wdata),
    .rq0_ready(rq0_ready),
    .rq1_valid(rq1_valid),
    .rq1_we   (rq1_we),
    .rq1_addr (rq1_addr),
    .rq1_wdata(rq1_wdata),
    .rq1_ready(rq1_ready),
    .rs0_valid(rs0_valid),
    .rs0_rdata(rs0_rdata),
    .rs1_valid(rs1_valid),
    .rs1_rdata(rs1_rdata),
    .clear_req(clear_req),
    .init_done(init_done),
    .mem_cea  (mem_cea),
    .mem_ada  (mem_ada),
    .mem_din  (mem_din),
    .mem_ceb  (mem_ceb),
    .mem_adb  (mem_adb),
    .mem_oce  (mem_oce),
    .mem_dout (mem_dout)
  );

  // Simple dual-port RAM, read port registered; a same-cycle collision returns old data.
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] dout_q;
  assign mem_dout = dout_q;

  always @(posedge clk) begin
    if (mem_cea) ram[mem_ada] <= mem_din;
    if (mem_ceb) dout_q <= ram[mem_adb];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    clear_req = 1'b0;
    rq0_valid = 1'b1; rq0_we = 1'b1; rq0_addr = '0; rq0_wdata = '0;
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;

    // Reset state, with requests present to show ready stays low.
    #2;
    chk("rst_cea",   32'(mem_cea),   32'd0);
    chk("rst_ceb",   32'(mem_ceb),   32'd0);
    chk("rst_init",  32'(init_done), 32'd0);
    chk("rst_ready", 32'({rq0_ready, rq1_ready}), 32'd0);
    chk("rst_rsv",   32'({rs0_valid, rs1_valid}), 32'd0);
    chk("oce_tied",  32'(mem_oce),   32'd1);
    @(negedge clk);
    @(negedge clk);

    // Zero-fill after reset release: 64 writes, then RUN.
    rq0_we = 1'b0; rq1_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("clr_cea",   32'(mem_cea),   32'd1);
      chk("clr_ada",   32'(mem_ada),   32'(i));
      chk("clr_din",   32'(mem_din),   32'd0);
      chk("clr_ready", 32'(rq0_ready), 32'd0);
      @(negedge clk);
    end
    rq0_valid = 1'b0;
    #1;
    chk("init_done_65", 32'(init_done), 32'd1);
    chk("idle_cea",     32'(mem_cea),   32'd0);
    @(negedge clk);

    // Contended writes to address 5 alternate rq0, rq1, rq0, rq1.
    rq0_valid = 1'b1; rq0_we = 1'b1; rq0_addr = 6'd5; rq0_wdata = 24'h000123;
    rq1_valid = 1'b1; rq1_we = 1'b1; rq1_addr = 6'd5; rq1_wdata = 24'h000456;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wr_rr_ready", 32'({rq0_ready, rq1_ready}), (i % 2 == 0) ? 32'b10 : 32'b01);
      chk("wr_rr_din",   32'(mem_din), (i % 2 == 0) ? 32'h000123 : 32'h000456);
      chk("wr_rr_ada",   32'(mem_ada), 32'd5);
      @(negedge clk);
    end
    rq1_valid = 1'b0; rq0_we = 1'b0;
    #1;
    chk("rd5_ready", 32'({rq0_ready, mem_ceb, mem_cea}), 32'b110);
    @(negedge clk);
    rq0_valid = 1'b0;
    #1;
    chk("rd5_rsv",   32'({rs0_valid, rs1_valid}), 32'b10);
    chk("rd5_data",  32'(rs0_rdata), 32'h000456);
    @(negedge clk);
    #1;
    chk("rd5_one_cycle", 32'(rs0_valid), 32'd0);
    chk("rd5_zero_data", 32'(rs0_rdata), 32'd0);
    @(negedge clk);

    // Plain read of address 3 by rq0.
    rq1_valid = 1'b1; rq1_we = 1'b1; rq1_addr = 6'd3; rq1_wdata = 24'h000777;
    #1;
    chk("wr3_ready", 32'(rq1_ready), 32'd1);
    @(negedge clk);
    rq1_valid = 1'b0;
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 6'd3;
    #1;
    chk("rd3_accept", 32'({rq0_ready, mem_ceb}), 32'b11);
    chk("rd3_adb",    32'(mem_adb), 32'd3);
    @(negedge clk);
    rq0_valid = 1'b0;
    #1;
    chk("rd3_rsv",  32'({rs0_valid, rs1_valid}), 32'b10);
    chk("rd3_data", 32'(rs0_rdata), 32'h000777);
    @(negedge clk);
    #1;
    chk("rd3_after", 32'({rs0_valid, rs1_valid}), 32'b00);
    @(negedge clk);

    // Same-cycle write (rq0) and read (rq1) of address 9: forwarding.
    rq0_valid = 1'b1; rq0_we = 1'b1; rq0_addr = 6'd9; rq0_wdata = 24'hABCDEF;
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 6'd9;
    #1;
    chk("fwd_ready", 32'({rq0_ready, rq1_ready}), 32'b11);
    chk("fwd_ce",    32'({mem_cea, mem_ceb}), 32'b11);
    @(negedge clk);
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    #1;
    chk("fwd_rsv",  32'({rs0_valid, rs1_valid}), 32'b01);
    chk("fwd_data", 32'(rs1_rdata), 32'hABCDEF);
    @(negedge clk);

    // Contended reads: rq0 first, then rq1, routed to the right response.
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 6'd3;
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 6'd9;
    #1;
    chk("rd_rr_first", 32'({rq0_ready, rq1_ready}), 32'b10);
    @(negedge clk);
    #1;
    chk("rd_rr_second", 32'({rq0_ready, rq1_ready}), 32'b01);
    chk("rd_rr_rs0",    32'({rs0_valid, rs1_valid}), 32'b10);
    chk("rd_rr_d0",     32'(rs0_rdata), 32'h000777);
    @(negedge clk);
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    #1;
    chk("rd_rr_rs1", 32'({rs0_valid, rs1_valid}), 32'b01);
    chk("rd_rr_d1",  32'(rs1_rdata), 32'hABCDEF);
    @(negedge clk);

    // Clear pulse from RUN: 64 blocked cycles, then reads return zero.
    clear_req = 1'b1;
    #1;
    chk("clrq_run_init", 32'(init_done), 32'd1);
    @(negedge clk);
    clear_req = 1'b0;
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 6'd9;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("reclr_state", 32'({init_done, rq0_ready, mem_cea}), 32'b001);
      chk("reclr_ada",   32'(mem_ada), 32'(i));
      @(negedge clk);
    end
    #1;
    chk("reclr_done", 32'({init_done, rq0_ready}), 32'b11);
    @(negedge clk);
    rq0_addr = 6'd5;
    #1;
    chk("reclr_rd9_v", 32'(rs0_valid), 32'd1);
    chk("reclr_rd9_d", 32'(rs0_rdata), 32'd0);
    @(negedge clk);
    rq0_valid = 1'b0;
    #1;
    chk("reclr_rd5_v", 32'(rs0_valid), 32'd1);
    chk("reclr_rd5_d", 32'(rs0_rdata), 32'd0);
    @(negedge clk);

    // Clear request during CLEAR restarts the sweep at address 0.
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("restart_pre_ada", 32'(mem_ada), 32'(j));
      @(negedge clk);
    end
    clear_req = 1'b1;
    #1;
    chk("restart_hit_ada", 32'(mem_ada), 32'd3);
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("restart_ada",  32'(mem_ada), 32'(i));
      chk("restart_init", 32'({init_done, mem_cea}), 32'b01);
      @(negedge clk);
    end
    #1;
    chk("restart_done", 32'(init_done), 32'd1);
    @(negedge clk);

    // Reset right after a read accept: no response, clear restarts at 0.
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 6'd3;
    #1;
    chk("rst_rd_accept", 32'(rq0_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rq0_valid = 1'b0;
    #1;
    chk("rst_no_resp", 32'({rs0_valid, rs1_valid}), 32'b00);
    chk("rst_no_cea",  32'({mem_cea, init_done}), 32'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_clr_a0",  32'({mem_cea, init_done}), 32'b10);
    chk("rst_clr_ada0", 32'(mem_ada), 32'd0);
    chk("rst_no_resp2", 32'({rs0_valid, rs1_valid}), 32'b00);
    @(negedge clk);
    #1;
    chk("rst_clr_ada1", 32'(mem_ada), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_ram_arbiter.md
POLY_RAM_ARBITER -- requirements
Module: poly_ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 6, meaning word-address width (64-entry coefficient RAM).
REQ-002 SHALL have parameter DW, default 24, meaning data width (two packed 12-bit coefficients).
REQ-003 SHALL have port clk  input  1  the single clock for the block and the RAM.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rq0_valid/rq1_valid  input  1 each  request present.
REQ-006 SHALL have ports rq0_we/rq1_we  input  1 each  1=write, 0=read.
REQ-007 SHALL have ports rq0_addr/rq1_addr  input  AW each  word address.
REQ-008 SHALL have ports rq0_wdata/rq1_wdata  input  DW each  write data.
REQ-009 SHALL have ports rq0_ready/rq1_ready  output  1 each  request accepted this cycle when valid&ready.
REQ-010 SHALL have ports rs0_valid/rs1_valid  output  1 each  read data valid.
REQ-011 SHALL have ports rs0_rdata/rs1_rdata  output  DW each  read data.
REQ-012 SHALL have port clear_req  input  1  pulse to start a zero-fill of the RAM.
REQ-013 SHALL have port init_done  output  1  high when in RUN state.
REQ-014 SHALL have ports mem_cea, mem_ada[AW-1:0], mem_din[DW-1:0]  output  write port A.
REQ-015 SHALL have ports mem_ceb, mem_adb[AW-1:0], mem_oce  output; mem_dout[DW-1:0]  input  read port B (bypass mode, 1-cycle latency).

Function
REQ-016 SHALL implement FSM states CLEAR and RUN; reset enters CLEAR.
REQ-017 In CLEAR SHALL write zero to addresses 0..2^AW-1, one per cycle, via a counter, then enter RUN; rq*_ready SHALL be 0.
REQ-018 clear_req in RUN SHALL enter CLEAR next cycle with counter reset to 0; clear_req during CLEAR SHALL restart the counter at 0.
REQ-019 In RUN, write requests SHALL be arbitrated to port A and read requests to port B independently; one read and one write SHALL be accepted in the same cycle.
REQ-020 Each port SHALL use 2-way round-robin: when both requesters contend, grant the one not granted last on that port; pointer updates only on a contended grant.
REQ-021 The pointer for each port SHALL reset to favour requester 0.
REQ-022 rq*_ready SHALL be combinational from valid, we and arbitration; mem_cea/mem_ceb SHALL be high only in cycles with an accepted write/read (or a CLEAR write).
REQ-023 An accepted read at cycle N SHALL produce rsN_valid high for exactly one cycle at N+1 with rsN_rdata valid that cycle only; the other requester's rs valid SHALL stay 0.
REQ-024 A read and write to the same address accepted in the same cycle SHALL return the new write data (forwarded, not mem_dout).
REQ-025 mem_oce SHALL be tied to 1.
REQ-026 rs*_rdata SHALL be 0 when rs*_valid is 0.

Reset
REQ-027 On rst_n low, asynchronously: state=CLEAR, clear counter=0, RR pointers=0, pending-read tag and forward flag cleared, rs*_valid=0, init_done=0, rq*_ready=0, mem_cea=mem_ceb=0.
REQ-028 A read accepted in the cycle before reset assertion SHALL NOT produce a response.

Structure
REQ-029 Package poly_ram_pkg SHALL hold AW/DW defaults, DEPTH=2**AW and the state enum {CLEAR, RUN}.
REQ-030 Round-robin logic SHALL be a sub-module rr_arb2 instantiated twice (write port, read port).

Verification
REQ-031 Reset release -> 64 consecutive mem_cea cycles with mem_din=0, addresses 0..63, then init_done=1 on cycle 65.
REQ-032 Both write addr 5 (rq0 data 0x000123, rq1 data 0x000456) continuously -> grants alternate rq0, rq1, rq0...; later read 5 returns last-granted data.
REQ-033 rq0 writes addr 9 = 0xABCDEF while rq1 reads addr 9 same cycle -> both ready; rs1_valid next cycle with 0xABCDEF.
REQ-034 rq0 reads addr 3 (holding 0x000777) -> rs0_valid exactly one cycle later with 0x000777, rs1_valid stays 0.
REQ-035 clear_req pulse in RUN after writes -> init_done drops, ready=0 for 64 cycles, subsequent reads return 0.
REQ-036 rst_n asserted one cycle after a read accept -> no rs*_valid, CLEAR restarts at address 0.
